// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, terminator encoding and fetch FSM states
package fetch_pkg;
  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam logic [ILEN-1:0] INSTR_SELF_LOOP = 32'h0000_0063;

  typedef enum logic [1:0] {IDLE, RUN, PARK} fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH-entry synchronous FIFO of {pc, instr} fetch entries
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           din,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output fetch_entry_t           head
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch unit: PC register, fetch FSM and enqueue into the fetch FIFO
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 64'h0,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            fetch_en,
  output logic [XLEN-1:0] imem_pc,
  input  logic [ILEN-1:0] imem_instr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [ILEN-1:0] out_instr,
  output logic            parked
);
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   count;
  logic            empty;
  logic            space;
  logic            enq;
  logic            deq;
  fetch_entry_t    head;
  fetch_entry_t    tail;
  logic            unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign out_valid = !empty;
  assign deq       = out_valid && out_ready;
  // A full FIFO still accepts a new entry when the head leaves this cycle.
  assign space     = (count < CW'(DEPTH)) || deq;
  assign enq       = (state_q == RUN) && fetch_en && !redirect_valid && space;
  assign tail      = '{pc: pc_q, instr: imem_instr};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (redirect_valid) begin
      pc_d    = {redirect_pc[XLEN-1:2], 2'b00};
      state_d = fetch_en ? RUN : IDLE;
    end else begin
      case (state_q)
        IDLE:    if (fetch_en) state_d = RUN;
        RUN: begin
          if (!fetch_en)                                   state_d = IDLE;
          else if (enq && imem_instr == INSTR_SELF_LOOP)   state_d = PARK;
        end
        PARK:    state_d = PARK;
        default: state_d = IDLE;
      endcase
      if (enq) pc_d = pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (enq),
    .pop   (deq),
    .flush (redirect_valid),
    .din   (tail),
    .count (count),
    .empty (empty),
    .head  (head)
  );

  assign imem_pc   = pc_q;
  assign out_pc    = head.pc;
  assign out_instr = head.instr;
  assign parked    = (state_q == PARK);
endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - scoreboard bench for instr_fetch against a stream-level fetch model
module tb_instr_fetch;
  logic        clk;
  logic        rstn;
  logic        fetch_en;
  logic [63:0] imem_pc;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        parked;

  logic [31:0] mem [0:63];
  logic [95:0] exp_q[$];
  logic [95:0] pend_q[$];
  logic [95:0] e;
  int n_checks = 0;
  int n_fail   = 0;

  instr_fetch dut (
    .clk            (clk),
    .rstn           (rstn),
    .fetch_en       (fetch_en),
    .imem_pc        (imem_pc),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .parked         (parked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Low 256 bytes come from the table; everything else is a never-terminating filler word.
  assign imem_instr = (imem_pc[63:8] == 56'd0) ? mem[imem_pc[7:2]] : (imem_pc[31:0] | 32'h1000_0000);

  function automatic logic [31:0] model_rd(input logic [63:0] a);
    if (a[63:8] == 56'd0) return mem[a[7:2]];
    return a[31:0] | 32'h1000_0000;
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, expv);
    end
  endtask

  // Expected program stream: consecutive words from start, ending at the self-loop.
  task automatic build_pend(input logic [63:0] start);
    logic [63:0] p;
    logic [31:0] w;
    pend_q.delete();
    p = start;
    for (int i = 0; i < 100; i++) begin
      w = model_rd(p);
      pend_q.push_back({p, w});
      if (w == 32'h0000_0063) break;
      p += 64'd4;
    end
  endtask

  always @(negedge clk) begin
    if (rstn && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got pc %0h instr %0h, required no output", out_pc, out_instr);
      end else begin
        e = exp_q.pop_front();
        chk("out_pair", {out_pc, out_instr}, e);
      end
    end
    if (rstn && redirect_valid) exp_q = pend_q;
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rstn = 1'b0; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    build_pend(64'h0);
    exp_q = pend_q;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic redirect_to(input logic [63:0] t);
    build_pend({t[63:2], 2'b00});
    redirect_pc    = t;
    redirect_valid = 1'b1;
  endtask

  task automatic drain(input string name);
    int k;
    redirect_valid = 1'b0; fetch_en = 1'b1; out_ready = 1'b1;
    k = 0;
    while (k < 300 && !(exp_q.size() == 0 && parked && !out_valid)) begin
      next_cycle;
      k++;
    end
    chk({name, "_remaining"}, exp_q.size(), 0);
    chk({name, "_parked"}, parked, 1);
  endtask

  task automatic load_prog1;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0013;
    mem[0] = 32'h0000_3083; mem[1] = 32'h0010_3103; mem[2] = 32'h0000_0063;
  endtask

  initial begin
    logic [31:0] w;
    rstn = 1'b0; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    load_prog1();
    #2;
    chk("reset_imem_pc", imem_pc, 64'h0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_parked", parked, 0);

    // Straight-line program ending in the self-loop.
    do_reset();
    fetch_en = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c < 2) chk($sformatf("prog_c%0d_valid", c), out_valid, 0);
      else if (c <= 4) begin
        chk($sformatf("prog_c%0d_valid", c), out_valid, 1);
        chk($sformatf("prog_c%0d_pc", c), out_pc, 64'(4 * (c - 2)));
      end else begin
        chk($sformatf("prog_c%0d_valid", c), out_valid, 0);
        chk($sformatf("prog_c%0d_parked", c), parked, 1);
        chk($sformatf("prog_c%0d_imem_pc", c), imem_pc, 64'd12);
      end
      next_cycle;
    end

    // Backpressure for five cycles, then full-FIFO pass-through.
    do_reset();
    fetch_en = 1'b1;
    for (int c = 0; c < 9; c++) begin
      out_ready = (c >= 5);
      @(negedge clk);
      if (c >= 3 && c <= 5) chk($sformatf("bp_c%0d_imem_pc", c), imem_pc, 64'd8);
      if (c >= 5 && c <= 7) begin
        chk($sformatf("bp_c%0d_valid", c), out_valid, 1);
        chk($sformatf("bp_c%0d_pc", c), out_pc, 64'(4 * (c - 5)));
      end
      if (c == 8) chk("bp_c8_valid", out_valid, 0);
      next_cycle;
    end

    // Random program with a terminator at 0x60.
    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      if (w == 32'h0000_0063) w = 32'h0000_0013;
      mem[i] = w;
    end
    mem[24] = 32'h0000_0063;

    // Redirect to 0x13 with two entries buffered and the head consumed that cycle.
    do_reset();
    fetch_en = 1'b1;
    repeat (4) next_cycle;
    out_ready = 1'b1;
    redirect_to(64'h13);
    @(negedge clk);
    chk("redir_head_valid", out_valid, 1);
    chk("redir_head_pc", out_pc, 64'h0);
    next_cycle;
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("redir_n1_valid", out_valid, 0);
    next_cycle;
    @(negedge clk);
    chk("redir_n2_valid", out_valid, 1);
    chk("redir_n2_pc", out_pc, 64'h10);
    drain("redir");

    // Leave PARK via redirect to 0.
    redirect_to(64'h0);
    next_cycle;
    redirect_valid = 1'b0;
    chk("park_exit", parked, 0);
    drain("park_redirect");

    // PC wrap past the top of the address space; low bits of the target are dropped.
    redirect_to(64'hFFFF_FFFF_FFFF_FFFF);
    next_cycle;
    drain("wrap");

    // Asynchronous reset with a full FIFO.
    redirect_to(64'h0);
    out_ready = 1'b0;
    next_cycle;
    redirect_valid = 1'b0;
    repeat (4) next_cycle;
    chk("pre_reset_valid", out_valid, 1);
    #2 rstn = 1'b0;
    build_pend(64'h0);
    exp_q = pend_q;
    #1;
    chk("async_reset_valid", out_valid, 0);
    chk("async_reset_imem_pc", imem_pc, 64'h0);
    chk("async_reset_parked", parked, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rstn = 1'b1;
    fetch_en = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("idle_c%0d_valid", c), out_valid, 0);
      chk($sformatf("idle_c%0d_imem_pc", c), imem_pc, 64'h0);
      next_cycle;
    end
    fetch_en = 1'b1;
    repeat (2) next_cycle;
    @(negedge clk);
    chk("idle_start_valid", out_valid, 1);
    chk("idle_start_pc", out_pc, 64'h0);
    drain("after_reset");

    // Randomized enable, backpressure and redirects.
    for (int i = 0; i < 800; i++) begin
      fetch_en  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      if ($urandom % 12 == 0) redirect_to({56'd0, 8'($urandom_range(0, 64))});
      else redirect_valid = 1'b0;
      next_cycle;
    end
    drain("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
